// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU memory stage and its data-memory responder.
// The master drives requests and accepts responses; the slave does the opposite.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory: one request in flight, IDLE -> WAIT -> RESP.
// Misaligned accesses report an error and never touch memory.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rst,
    dmem_responder_if.slave     bus,
    input  logic [31:0]         show_addr,
    output logic [31:0]         show_data,
    output logic                busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IW    = DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [IW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     mem_q [DEPTH];
    logic            mem_we;
    logic [IW-1:0]   idx;
    logic            unused_addr_bits;

    // Upper address bits alias onto the same words by design.
    assign unused_addr_bits = ^{bus.req_addr[31:IW+2], show_addr[31:IW+2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        idx     = addr_q[IW+1:2];

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr[IW+1:0];
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (addr_q[1:0] != 2'b00) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        // Read sees the pre-write array; only one access commits per cycle anyway.
                        rdata_d = mem_q[idx];
                        err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Captured request and storage are data only; reset must not disturb memory.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        if (mem_we) mem_q[idx] <= wdata_q;
    end

    assign bus.req_ready  = (state_q == IDLE) && rst;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign busy           = (state_q != IDLE);
    assign show_data      = mem_q[show_addr[IW+1:2]];
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_responder;
    localparam int DL    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] show_addr = '0;
    logic [31:0] show_data;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];

    dmem_responder_if bus_if ();

    dmem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .show_addr (show_addr),
        .show_data (show_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic garbage();
        bus_if.req_valid = 1'($urandom);
        bus_if.req_we    = 1'($urandom);
        bus_if.req_addr  = $urandom;
        bus_if.req_wdata = $urandom;
    endtask

    // One complete transaction; hold = cycles the response is left unaccepted.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          idx;
        int          n;
        exp_err = (addr[1:0] != 2'b00);
        idx     = widx(addr);
        exp_rd  = (!exp_err && !we) ? model[idx] : 32'h0;
        if (!exp_err && we) model[idx] = wd;

        @(negedge clk);
        chk("req_ready_idle", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wd;
        bus_if.resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        garbage();
        n = 1;
        while (!bus_if.resp_valid && n < 20) begin
            chk("req_ready_wait", 32'(bus_if.req_ready), 32'd0);
            @(negedge clk);
            garbage();
            n++;
        end
        chk("latency", 32'(n), 32'(LAT + 1));
        chk("resp_valid", 32'(bus_if.resp_valid), 32'd1);
        chk("resp_rdata", bus_if.resp_rdata, exp_rd);
        chk("resp_err", 32'(bus_if.resp_err), 32'(exp_err));
        chk("req_ready_resp", 32'(bus_if.req_ready), 32'd0);
        chk("busy_resp", 32'(busy), 32'd1);
        show_addr = addr;
        #1;
        chk("show_data", show_data, model[idx]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            garbage();
            chk("hold_valid", 32'(bus_if.resp_valid), 32'd1);
            chk("hold_rdata", bus_if.resp_rdata, exp_rd);
            chk("hold_err", 32'(bus_if.resp_err), 32'(exp_err));
            chk("hold_req_ready", 32'(bus_if.req_ready), 32'd0);
        end
        bus_if.resp_ready = 1'b1;
        bus_if.req_valid  = 1'b1;
        @(negedge clk);
        bus_if.req_valid  = 1'b0;
        bus_if.resp_ready = 1'b0;
        chk("post_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_req_ready", 32'(bus_if.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] old80;
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        bus_if.resp_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        chk("rst_rdata", bus_if.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus_if.resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_req_ready", 32'(bus_if.req_ready), 32'd1);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i) << 2, $urandom, 0);

        xact(1'b1, 32'h40, 32'h12345678, 0);
        xact(1'b0, 32'h40, 32'h0, 0);
        xact(1'b1, 32'h42, 32'hDEADBEEF, 0);
        show_addr = 32'h40;
        #1;
        chk("misaligned_no_write", show_data, 32'h12345678);
        xact(1'b1, 32'h400, 32'hA5A5A5A5, 0);
        show_addr = 32'h0;
        #1;
        chk("wrap_show", show_data, 32'hA5A5A5A5);
        xact(1'b0, 32'h40, 32'h0, 5);

        // Reset while a store waits: no commit, outputs drop at once.
        old80 = model[widx(32'h80)];
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 32'h80;
        bus_if.req_wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready", 32'(bus_if.req_ready), 32'd0);
        chk("abort_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        chk("abort_rdata", bus_if.resp_rdata, 32'd0);
        chk("abort_err", 32'(bus_if.resp_err), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_hold_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_rel_ready", 32'(bus_if.req_ready), 32'd1);
        show_addr = 32'h80;
        #1;
        chk("abort_word80", show_data, old80);
        xact(1'b0, 32'h80, 32'h0, 0);

        // Randomized mixed traffic with aliasing addresses.
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            xact(1'($urandom), a, $urandom, int'($urandom_range(3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
